apb_periph_bridge_nslv: RTL and testbench
=========================================

Name: apb_periph_bridge_nslv

Overview:
- Parametrised LINT-to-APB3/APB4 bridge with a built-in N-way address decoder. It replaces the separate protocol bridge and fixed three-slave bus wrap in the peripheral subsystem.
- Accepts one core data-side request at a time and runs one APB transfer to the selected slave.
- Returns read data and an error flag.
- Adds unmapped-address error response, PSTRB, and a per-access PREADY timeout.

Parameters:
- NUM_SLAVES, 4, number of APB slave ports (1..16).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).
- BASE_ADDR, 32'h1A10_0000, base of the peripheral window.
- REGION_LSB, 12, log2 of per-slave region size (4 KiB).
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- data_req_i  in  1  request.
- data_add_i  in  ADDR_WIDTH  byte address.
- data_wen_i  in  1  1 = write, 0 = read.
- data_wdata_i  in  DATA_WIDTH  write data.
- data_be_i  in  DATA_WIDTH/8  byte enables.
- data_gnt_o  out  1  request accepted.
- data_r_valid_o  out  1  response valid, one-cycle pulse.
- data_r_rdata_o  out  DATA_WIDTH  read data.
- data_r_err_o  out  1  error response.
- apb_paddr_o  out  ADDR_WIDTH  PADDR, shared by all slaves.
- apb_pwdata_o  out  DATA_WIDTH  PWDATA.
- apb_pwrite_o  out  1  PWRITE.
- apb_pstrb_o  out  DATA_WIDTH/8  PSTRB; forced to 0 on reads.
- apb_psel_o  out  NUM_SLAVES  one-hot PSEL.
- apb_penable_o  out  1  PENABLE.
- apb_prdata_i  in  NUM_SLAVES*DATA_WIDTH  per-slave PRDATA; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- apb_pready_i  in  NUM_SLAVES  per-slave PREADY.
- apb_pslverr_i  in  NUM_SLAVES  per-slave PSLVERR.

Behaviour:
- Clocking and reset: single clock domain (clk). rst_n is synchronous and active-low.
- Reset values:
  - All outputs 0; FSM in IDLE; timeout counter 0.
  - Reset asserted mid-transfer aborts the transfer: PSEL/PENABLE drop the next edge and no response is issued.
- Address decode:
  - IDX_W = max(1, clog2(NUM_SLAVES)); idx = data_add_i[REGION_LSB+IDX_W-1:REGION_LSB].
  - Hit when data_add_i[ADDR_WIDTH-1:REGION_LSB+IDX_W] == BASE_ADDR[same bits] AND idx < NUM_SLAVES.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: data_gnt_o = data_req_i, combinational.
    - On grant: register address, wdata, be and wen.
    - Hit: go to SETUP.
    - Miss: stay in IDLE and pulse data_r_valid_o next cycle with err=1, rdata=0. The APB bus is untouched.
  - SETUP: psel[idx]=1, penable=0; go to ACCESS unconditionally.
  - ACCESS: psel[idx]=1, penable=1; timeout counter increments each cycle.
    - pready[idx]=1: go to IDLE; next cycle data_r_valid_o=1, err=pslverr[idx], rdata=prdata[idx] for reads and 0 for writes.
    - Timeout, i.e. counter reaches TIMEOUT_CYCLES while pready[idx]=0: go to IDLE; next cycle valid=1, err=1, rdata=0; counter clears.
- APB signals: paddr/pwdata/pwrite/pstrb are stable from SETUP through the end of ACCESS.
- Latency:
  - Hit with zero wait states: gnt at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, r_valid at cycle 3.
  - Miss: r_valid at cycle 1.
- Back-to-back: a new grant is allowed in the same cycle as r_valid, since the FSM is already in IDLE. Throughput is one transfer per 3 cycles.
- Request hold: data_req_i is ignored outside IDLE (gnt=0). The requester holds req until gnt.
- Response data: data_r_rdata_o and data_r_err_o are 0 whenever r_valid=0.
- Unselected slaves: PREADY and PSLVERR from unselected slaves are ignored.

Test Plan:
- Read slave 2 (addr 0x1A10_2004), slave returns prdata=0xCAFE_0002 with zero wait -> psel=4'b0100 at cycles 1–2, penable at cycle 2 only, r_valid at cycle 3, rdata=0xCAFE_0002, err=0.
- Write 0xA5A5_A5A5, be=4'b0011 to 0x1A10_0010 with 3 wait states -> pstrb=4'b0011, pwrite=1, ACCESS lasts 4 cycles, r_valid at cycle 6, rdata=0, err=0.
- Read 0x1A10_4000 (outside window) and, with NUM_SLAVES=3, read 0x1A10_3000 -> psel stays 0, r_valid at cycle 1, err=1, rdata=0.
- Slave 1 asserts pslverr with pready -> err=1; a back-to-back request granted in the r_valid cycle proceeds to its own SETUP the next cycle.
- TIMEOUT_CYCLES=8, slave 3 never asserts pready -> after 8 ACCESS cycles psel/penable drop, r_valid with err=1; the next request completes normally.
- rst_n low during ACCESS -> all outputs 0 next edge, no r_valid; a fresh read after reset completes normally.

Source files
------------

// File: rtl/apb_periph_bridge_nslv.sv
// Core data-side (LINT) to APB bridge with an N-way region decoder, unmapped-address
// error response, PSTRB generation and a per-access PREADY timeout.
module apb_periph_bridge_nslv #(
    parameter int                    NUM_SLAVES     = 4,
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1A10_0000,
    parameter int                    REGION_LSB     = 12,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             data_req_i,
    input  logic [ADDR_WIDTH-1:0]            data_add_i,
    input  logic                             data_wen_i,
    input  logic [DATA_WIDTH-1:0]            data_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          data_be_i,
    output logic                             data_gnt_o,
    output logic                             data_r_valid_o,
    output logic [DATA_WIDTH-1:0]            data_r_rdata_o,
    output logic                             data_r_err_o,
    output logic [ADDR_WIDTH-1:0]            apb_paddr_o,
    output logic [DATA_WIDTH-1:0]            apb_pwdata_o,
    output logic                             apb_pwrite_o,
    output logic [DATA_WIDTH/8-1:0]          apb_pstrb_o,
    output logic [NUM_SLAVES-1:0]            apb_psel_o,
    output logic                             apb_penable_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] apb_prdata_i,
    input  logic [NUM_SLAVES-1:0]            apb_pready_i,
    input  logic [NUM_SLAVES-1:0]            apb_pslverr_i
);

    localparam int IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TAG_LSB = REGION_LSB + IDX_W;
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [IDX_W:0] NUM_S = (IDX_W + 1)'(NUM_SLAVES);
    localparam logic [ADDR_WIDTH-TAG_LSB-1:0] BASE_TAG = BASE_ADDR[ADDR_WIDTH-1:TAG_LSB];

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic                  wen_q;
    logic [IDX_W-1:0]      idx_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  gnt;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_hit;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  timeout_hit;

    always_comb begin
        req_idx = data_add_i[REGION_LSB +: IDX_W];
        req_hit = (data_add_i[ADDR_WIDTH-1:TAG_LSB] == BASE_TAG) && ({1'b0, req_idx} < NUM_S);
    end

    // Only the latched target slave is ever looked at; all other PREADY/PSLVERR are ignored.
    always_comb begin
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_rdata  = '0;
        apb_psel_o = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_ready     = apb_pready_i[i];
                sel_err       = apb_pslverr_i[i];
                sel_rdata     = apb_prdata_i[i*DATA_WIDTH +: DATA_WIDTH];
                apb_psel_o[i] = (state_q != IDLE);
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rdata_d  = '0;
        gnt      = 1'b0;
        case (state_q)
            IDLE: begin
                gnt = data_req_i && rst_n;
                if (gnt) begin
                    if (req_hit) begin
                        state_d = SETUP;
                    end else begin
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (sel_ready) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rerr_d   = sel_err;
                    rdata_d  = wen_q ? '0 : sel_rdata;
                end else if (timeout_hit) begin
                    state_d  = IDLE;
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wen_q    <= 1'b0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
            if (gnt) begin
                addr_q  <= data_add_i;
                wdata_q <= data_wdata_i;
                be_q    <= data_be_i;
                wen_q   <= data_wen_i;
                idx_q   <= req_idx;
            end
        end
    end

    assign data_gnt_o     = gnt;
    assign data_r_valid_o = rvalid_q;
    assign data_r_rdata_o = rdata_q;
    assign data_r_err_o   = rerr_q;
    assign apb_paddr_o    = addr_q;
    assign apb_pwdata_o   = wdata_q;
    assign apb_pwrite_o   = wen_q;
    assign apb_pstrb_o    = wen_q ? be_q : '0;
    assign apb_penable_o  = (state_q == ACCESS);

endmodule

// File: tb/tb_apb_periph_bridge_nslv.sv
// Scoreboard bench for apb_periph_bridge_nslv: per-slave APB responder model with
// configurable wait states / PSLVERR, expected responses queued at grant time.
module tb_apb_periph_bridge_nslv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         req, wen;
    logic [31:0]  add, wdata;
    logic [3:0]   be;
    logic         gnt, r_valid, r_err;
    logic [31:0]  r_rdata, paddr, pwdata;
    logic         pwrite, penable;
    logic [3:0]   pstrb, psel;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;

    logic         req3;
    logic [31:0]  add3;
    logic         gnt3, rvalid3, rerr3, pwrite3, penable3;
    logic [31:0]  rdata3, paddr3, pwdata3;
    logic [3:0]   pstrb3;
    logic [2:0]   psel3;

    int   wait_cfg[4];
    logic err_cfg[4];
    int   acc_cnt = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    apb_periph_bridge_nslv #(.NUM_SLAVES(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req), .data_add_i(add), .data_wen_i(wen),
        .data_wdata_i(wdata), .data_be_i(be), .data_gnt_o(gnt),
        .data_r_valid_o(r_valid), .data_r_rdata_o(r_rdata), .data_r_err_o(r_err),
        .apb_paddr_o(paddr), .apb_pwdata_o(pwdata), .apb_pwrite_o(pwrite),
        .apb_pstrb_o(pstrb), .apb_psel_o(psel), .apb_penable_o(penable),
        .apb_prdata_i(prdata), .apb_pready_i(pready), .apb_pslverr_i(pslverr)
    );

    apb_periph_bridge_nslv #(.NUM_SLAVES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .data_req_i(req3), .data_add_i(add3), .data_wen_i(1'b0),
        .data_wdata_i(32'h0), .data_be_i(4'hF), .data_gnt_o(gnt3),
        .data_r_valid_o(rvalid3), .data_r_rdata_o(rdata3), .data_r_err_o(rerr3),
        .apb_paddr_o(paddr3), .apb_pwdata_o(pwdata3), .apb_pwrite_o(pwrite3),
        .apb_pstrb_o(pstrb3), .apb_psel_o(psel3), .apb_penable_o(penable3),
        .apb_prdata_i({32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000}),
        .apb_pready_i(3'b111), .apb_pslverr_i(3'b000)
    );

    // Unselected slaves drive PREADY/PSLVERR high so any leakage into the response shows up.
    always_comb begin
        prdata  = '0;
        pready  = '1;
        pslverr = '1;
        for (int i = 0; i < 4; i++) begin
            prdata[i*32 +: 32] = 32'hCAFE_0000 + i;
            if (psel[i]) begin
                pready[i]  = penable && (acc_cnt == wait_cfg[i]);
                pslverr[i] = penable && err_cfg[i];
            end
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (penable && ((psel & pready) == 4'b0000)) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        else n_pass++;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (r_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rvalid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rdata", r_rdata, e.rdata);
                    chk("err", r_err, e.err);
                    chk("rvalid_cycle", cyc, e.cyc);
                end
            end else begin
                chk("idle_resp_zero", {r_rdata, r_err}, 64'd0);
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, input logic [31:0] er, input logic ee,
                          input int lat, input bit push, output int gcyc);
        bit got;
        got  = 1'b0;
        gcyc = -1;
        @(negedge clk);
        req = 1'b1; add = a; wen = w; wdata = d; be = b;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (gnt) begin
                got  = 1'b1;
                gcyc = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk("gnt_wait", got, 1);
        if (got && push) begin
            exp_t e;
            e.rdata = er;
            e.err   = ee;
            e.cyc   = gcyc + lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    initial begin
        int g, g1, g2, n;
        rst_n = 1'b0; req = 1'b0; add = '0; wen = 1'b0; wdata = '0; be = '0;
        req3 = 1'b0; add3 = '0;
        for (int i = 0; i < 4; i++) begin
            wait_cfg[i] = 0;
            err_cfg[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        req = 1'b1; add = 32'h1A10_2004;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rvalid", r_valid, 0);
        chk("rst_paddr", paddr, 0);
        req = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // zero-wait read of slave 2
        do_req(32'h1A10_2004, 1'b0, 32'h0, 4'hF, 32'hCAFE_0002, 1'b0, 3, 1'b1, g);
        @(negedge clk);
        chk("rd_setup_psel", psel, 4'b0100);
        chk("rd_setup_penable", penable, 0);
        chk("rd_paddr", paddr, 32'h1A10_2004);
        chk("rd_pstrb", pstrb, 0);
        chk("rd_pwrite", pwrite, 0);
        @(negedge clk);
        chk("rd_access_psel", psel, 4'b0100);
        chk("rd_access_penable", penable, 1);
        @(negedge clk);
        chk("rd_done_psel", psel, 0);
        chk("rd_done_penable", penable, 0);

        // write with 3 wait states to slave 0
        wait_cfg[0] = 3;
        do_req(32'h1A10_0010, 1'b1, 32'hA5A5_A5A5, 4'b0011, 32'h0, 1'b0, 6, 1'b1, g);
        @(negedge clk);
        chk("wr_pstrb", pstrb, 4'b0011);
        chk("wr_pwrite", pwrite, 1);
        chk("wr_pwdata", pwdata, 32'hA5A5_A5A5);
        chk("wr_psel", psel, 4'b0001);
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (penable) begin
                n++;
                chk("wr_pstrb_hold", pstrb, 4'b0011);
            end
        end
        chk("wr_access_len", n, 4);
        wait_cfg[0] = 0;

        // unmapped addresses
        do_req(32'h1A10_4000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1, 1'b1, g);
        @(negedge clk);
        chk("miss_psel", psel, 0);
        chk("miss_penable", penable, 0);
        do_req(32'h1B10_0000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 1, 1'b1, g);
        repeat (2) @(negedge clk);

        // three-slave instance: index 3 is unmapped, index 2 is a hit
        add3 = 32'h1A10_3000; req3 = 1'b1;
        #1 chk("n3_miss_gnt", gnt3, 1);
        @(posedge clk);
        #1 req3 = 1'b0;
        @(negedge clk);
        chk("n3_miss_rvalid", rvalid3, 1);
        chk("n3_miss_err", rerr3, 1);
        chk("n3_miss_rdata", rdata3, 0);
        chk("n3_miss_psel", psel3, 0);
        add3 = 32'h1A10_2000; req3 = 1'b1;
        #1 chk("n3_hit_gnt", gnt3, 1);
        @(posedge clk);
        #1 req3 = 1'b0;
        @(negedge clk);
        chk("n3_hit_psel", psel3, 3'b100);
        @(negedge clk);
        chk("n3_hit_penable", penable3, 1);
        @(negedge clk);
        chk("n3_hit_rvalid", rvalid3, 1);
        chk("n3_hit_err", rerr3, 0);
        chk("n3_hit_rdata", rdata3, 32'hBEEF_0002);

        // PSLVERR from slave 1, then a back-to-back read
        err_cfg[1] = 1'b1;
        do_req(32'h1A10_1008, 1'b0, 32'h0, 4'hF, 32'hCAFE_0001, 1'b1, 3, 1'b1, g1);
        do_req(32'h1A10_2000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0002, 1'b0, 3, 1'b1, g2);
        chk("b2b_gnt_cycle", g2, g1 + 3);
        @(negedge clk);
        chk("b2b_setup_psel", psel, 4'b0100);
        chk("b2b_setup_penable", penable, 0);
        repeat (3) @(negedge clk);
        err_cfg[1] = 1'b0;

        // slave 3 never ready: timeout after 8 ACCESS cycles
        wait_cfg[3] = 1000;
        do_req(32'h1A10_3000, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, 10, 1'b1, g);
        n = 0;
        repeat (9) begin
            @(negedge clk);
            if (penable) n++;
        end
        chk("to_access_len", n, 8);
        @(negedge clk);
        chk("to_psel", psel, 0);
        chk("to_penable", penable, 0);
        do_req(32'h1A10_0000, 1'b0, 32'h0, 4'hF, 32'hCAFE_0000, 1'b0, 3, 1'b1, g);
        repeat (3) @(negedge clk);

        // reset during ACCESS aborts without a response
        do_req(32'h1A10_3004, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 0, 1'b0, g);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_psel", psel, 0);
        chk("abort_penable", penable, 0);
        chk("abort_rvalid", r_valid, 0);
        req = 1'b1;
        #1 chk("abort_gnt", gnt, 0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(32'h1A10_2008, 1'b0, 32'h0, 4'hF, 32'hCAFE_0002, 1'b0, 3, 1'b1, g);
        repeat (4) @(negedge clk);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
